// File: rtl/digit_display_scan_pkg.sv
// Shared constants for the multiplexed BCD display scanner: default parameters
// and active-low seven-segment patterns ordered {g,f,e,d,c,b,a}.
package digit_display_scan_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_SCAN_DIV     = 1000;
  localparam int DEF_BLINK_FRAMES = 64;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/digit_display_scan_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import digit_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_display_scan.sv
// Time-multiplexed scanner for a common-anode BCD display with a per-frame input
// snapshot, leading-zero blanking, decimal points and per-digit blinking.
module digit_display_scan
  import digit_display_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    blank_lz_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  logic [SLOT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  logic [NUM_DIGITS-1:0][3:0] snap_digits;
  logic [NUM_DIGITS-1:0]      snap_dp;
  logic [NUM_DIGITS-1:0]      snap_blink;
  logic                       snap_lz;

  logic                       frame_start, slot_last, frame_last;
  logic [NUM_DIGITS-1:0][3:0] eff_digits;
  logic [NUM_DIGITS-1:0]      eff_dp, eff_blink, lz_vec;
  logic                       eff_lz, nz_seen, lz_off, blink_off;
  logic [3:0]                 cur_digit;
  logic [6:0]                 seg_dec;

  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d, frame_d;

  // The first cycle of a frame already shows the inputs being captured this edge.
  always_comb begin
    frame_start = (idx == '0) && (slot_cnt == '0);
    slot_last   = slot_cnt == SLOT_W'(SCAN_DIV - 1);
    frame_last  = slot_last && (idx == IDX_W'(NUM_DIGITS - 1));
    eff_digits  = frame_start ? digits_i     : snap_digits;
    eff_dp      = frame_start ? dp_mask_i    : snap_dp;
    eff_blink   = frame_start ? blink_mask_i : snap_blink;
    eff_lz      = frame_start ? blank_lz_i   : snap_lz;
    cur_digit   = eff_digits[idx];
  end

  // lz_vec[i] is set when digit i and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    nz_seen = 1'b0;
    lz_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_seen   = nz_seen | (eff_digits[i] != 4'd0);
      lz_vec[i] = ~nz_seen;
    end
    lz_off    = eff_lz && lz_vec[idx];
    blink_off = blink_phase && eff_blink[idx];
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (seg_dec)
  );

  // NOTE: every output of this block is given a default first so no path can infer a latch.
  always_comb begin
    an_d    = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    frame_d = 1'b0;
    if (en_i) begin
      if (slot_cnt != '0) an_d = ~(NUM_DIGITS'(1) << idx);
      seg_d   = (blink_off || lz_off) ? SEG_BLANK : seg_dec;
      dp_d    = ~(eff_dp[idx] && !blink_off);
      frame_d = frame_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the snapshot is
  // a handful of flops, so it is cleared on reset like the counters.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
      an_o        <= '1;
      seg_o       <= SEG_BLANK;
      dp_o        <= 1'b1;
      frame_o     <= 1'b0;
    end else begin
      an_o    <= an_d;
      seg_o   <= seg_d;
      dp_o    <= dp_d;
      frame_o <= frame_d;
      if (!en_i) begin
        slot_cnt    <= '0;
        idx         <= '0;
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end else begin
        slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
        if (slot_last) idx <= frame_last ? '0 : idx + 1'b1;
        if (frame_last) begin
          if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        if (frame_start) begin
          snap_digits <= digits_i;
          snap_dp     <= dp_mask_i;
          snap_blink  <= blink_mask_i;
          snap_lz     <= blank_lz_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_display_scan.sv
// Self-checking bench for digit_display_scan: directed scenarios plus random
// traffic, compared against a time-based reference model of the display.
module tb_digit_display_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = N * SD;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b0;
  logic           en_i = 1'b0;
  logic [4*N-1:0] digits_i = '0;
  logic           blank_lz_i = 1'b0;
  logic [N-1:0]   dp_mask_i = '0;
  logic [N-1:0]   blink_mask_i = '0;
  logic [N-1:0]   an_o;
  logic [6:0]     seg_o;
  logic           dp_o;
  logic           frame_o;

  digit_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .en_i         (en_i),
    .digits_i     (digits_i),
    .blank_lz_i   (blank_lz_i),
    .dp_mask_i    (dp_mask_i),
    .blink_mask_i (blink_mask_i),
    .an_o         (an_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .frame_o      (frame_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_table [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  // Model state: cycles elapsed since scanning (re)started, and the frame snapshot.
  int             m_pos = 0;
  logic [4*N-1:0] m_digits = '0;
  logic [N-1:0]   m_dp = '0;
  logic [N-1:0]   m_blink = '0;
  logic           m_lz = 1'b0;
  int             n_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: the model sees the same inputs the DUT samples, outputs checked 1 time unit later.
  task automatic tick(input string tag);
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp, e_frame, active;
    int           idx, slot, frame, msnz;
    logic [3:0]   d;
    logic         lz_off, blink_off;
    @(posedge clk_i);
    active = 1'b0;
    e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    if (!reset_i) begin
      m_pos = 0; m_digits = '0; m_dp = '0; m_blink = '0; m_lz = 1'b0;
    end else if (!en_i) begin
      m_pos = 0;
    end else begin
      if (m_pos % FR == 0) begin
        m_digits = digits_i; m_dp = dp_mask_i; m_blink = blink_mask_i; m_lz = blank_lz_i;
      end
      slot  = m_pos % SD;
      idx   = (m_pos / SD) % N;
      frame = m_pos / FR;
      msnz  = -1;
      for (int i = 0; i < N; i++) if (m_digits[4*i +: 4] != 4'd0) msnz = i;
      d         = m_digits[4*idx +: 4];
      lz_off    = m_lz && idx > 0 && idx > msnz;
      blink_off = ((frame / BF) % 2 == 1) && m_blink[idx];
      e_seg     = (lz_off || blink_off) ? 7'h7F : seg_table[d];
      e_dp      = !(m_dp[idx] && !blink_off);
      e_frame   = (m_pos % FR) == FR - 1;
      if (slot != 0) begin
        e_an   = '1;
        e_an[idx] = 1'b0;
        active = 1'b1;
      end
      m_pos++;
    end
    #1;
    if (frame_o) n_frames++;
    check({tag, ".an"}, 32'(an_o), 32'(e_an));
    check({tag, ".frame"}, 32'(frame_o), 32'(e_frame));
    if (active || !reset_i || !en_i) begin
      check({tag, ".seg"}, 32'(seg_o), 32'(e_seg));
      check({tag, ".dp"}, 32'(dp_o), 32'(e_dp));
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Advance until the model is at a given position within the frame (bounded).
  task automatic run_to(input string tag, input int frame_pos);
    int guard = 0;
    while (m_pos % FR != frame_pos && guard < 4 * FR) begin
      tick(tag);
      guard++;
    end
    check({tag, ".reach"}, 32'(guard < 4 * FR), 32'd1);
  endtask

  logic [N-1:0] t1_seq [6] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
  int           frames_before;

  initial begin
    // Test 1: reset, then enable with 1234
    reset_i = 1'b0; en_i = 1'b1; digits_i = 16'h1234;
    run("reset", 3);
    reset_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("t1");
      check("t1_an_seq", 32'(an_o), 32'(t1_seq[i]));
      if (i >= 1 && i <= 3) check("t1_seg4", 32'(seg_o), 32'(7'b0011001));
    end
    run_to("t1", 0);
    run("t1", FR);

    // Test 2: leading-zero blanking
    blank_lz_i = 1'b1; digits_i = 16'h0070;
    run("t2a", FR);
    digits_i = 16'h0000;
    run("t2b", FR);
    blank_lz_i = 1'b0;

    // Test 3: invalid code with decimal point on digit 2
    digits_i = 16'h0B00; dp_mask_i = 4'b0100;
    run("t3", FR);
    dp_mask_i = '0;

    // Test 4: tearing, plus one frame pulse per 16 cycles
    digits_i = 16'h1234;
    run_to("t4", 0);
    frames_before = n_frames;
    run("t4", 6);
    digits_i = 16'h5678;
    run("t4", 2 * FR - 6);
    check("t4_frame_count", 32'(n_frames - frames_before), 32'd2);

    // Test 5: blink digit 0 across six frames from a fresh start
    en_i = 1'b0; blink_mask_i = 4'b0001; dp_mask_i = 4'b0011;
    run("t5", 2);
    en_i = 1'b1;
    run("t5", 6 * FR + 2);
    blink_mask_i = '0; dp_mask_i = '0;

    // Test 6: disable at index 2, restart; reset pulse mid-frame
    run_to("t6", 9);
    en_i = 1'b0;
    tick("t6_dis");
    check("t6_dis_an", 32'(an_o), 32'hF);
    run("t6_dis", 3);
    en_i = 1'b1;
    run("t6_en", FR + 3);
    reset_i = 1'b0;
    tick("t6_rst");
    reset_i = 1'b1;
    run("t6_rel", FR + 2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++)
          digits_i[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        blank_lz_i   = 1'($urandom);
        dp_mask_i    = N'($urandom);
        blink_mask_i = N'($urandom);
      end
      en_i    = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      reset_i = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_display_scan.md
DIGIT_DISPLAY_SCAN -- requirements
Module: digit_display_scan

Interface
REQ-001 Parameter NUM_DIGITS, 4, number of BCD digits scanned (2..8).
REQ-002 Parameter SCAN_DIV, 1000, clock cycles per digit slot (>=4).
REQ-003 Parameter BLINK_FRAMES, 64, complete frames per blink phase (>=1).
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-low reset.
REQ-006 en_i  in  1  display enable, level-sensitive.
REQ-007 digits_i  in  4*NUM_DIGITS  BCD digits; digit 0 (LSD) at [3:0].
REQ-008 blank_lz_i  in  1  leading-zero blanking enable.
REQ-009 dp_mask_i  in  NUM_DIGITS  decimal point on, per digit.
REQ-010 blink_mask_i  in  NUM_DIGITS  blink enable, per digit.
REQ-011 an_o  out  NUM_DIGITS  digit select, active-low, one-cold.
REQ-012 seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp_o  out  1  decimal point, active-low.
REQ-014 frame_o  out  1  one-cycle pulse in the last cycle of each full frame.

Function
REQ-015 A slot counter counts 0..SCAN_DIV-1 and wraps; at the wrap the digit index advances 0,1,..,NUM_DIGITS-1,0.
REQ-016 At the start of each frame (index 0, slot count 0), the block snapshots digits_i, dp_mask_i, blink_mask_i and blank_lz_i; the display reads only the snapshot for the whole frame.
REQ-017 an_o, seg_o, dp_o and frame_o are registered; they reflect the current index and snapshot with 1-cycle latency.
REQ-018 In slot count 0 of every slot, an_o is all ones (ghosting guard); in all other slot counts, only bit [index] of an_o is 0.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 BCD codes 10..15 display a dash (seg_o=0111111).
REQ-021 With blank_lz set, zero digits above the most significant nonzero digit show seg_o=1111111; digit 0 is never blanked; an all-zero value shows a single "0".
REQ-022 dp_o=0 when dp_mask bit [index] is set and the digit is not blink-blanked; a digit blanked by leading-zero blanking still shows its dp.
REQ-023 A blink phase bit toggles after each BLINK_FRAMES frames; while the phase is 1, digits with their blink_mask bit set show seg_o=1111111 and dp_o=1.
REQ-024 frame_o pulses when index=NUM_DIGITS-1 and slot count=SCAN_DIV-1, registered.
REQ-025 With en_i low: an_o, seg_o and dp_o are all ones, frame_o is 0, and the slot, index and blink counters hold at 0.
REQ-026 When en_i rises, scanning starts at index 0, slot count 0, with a new snapshot; the first digit is active 2 cycles after en_i is sampled high.
REQ-027 Changes to digits_i during a frame have no effect until the next frame boundary.

Reset
REQ-028 When reset_i is sampled 0, the block clears the slot, index, frame and blink counters and the blink phase, and clears the snapshot to 0.
REQ-029 Reset values: an_o all ones, seg_o=1111111, dp_o=1, frame_o=0.
REQ-030 Reset asserted mid-frame discards the frame; after release, behaviour follows REQ-026 if en_i is high.

Structure
REQ-031 A shared package holds the segment pattern constants (digits 0-9, DASH, BLANK) and the default values of NUM_DIGITS, SCAN_DIV and BLINK_FRAMES.
REQ-032 BCD-to-segment decoding is a combinational sub-module bcd_to_seg7 (4-bit input, 7-bit active-low output, dash for codes above 9), instantiated once.
REQ-033 The top level contains only counters, the snapshot, blanking/blink logic and output registers; there are no latches and no gated clocks.

Verification
REQ-034 Test 1, reset and enable: NUM_DIGITS=4, SCAN_DIV=4, en_i=1, digits 0x1234, release reset -> an_o sequence 1111,1110,1110,1110,1111,1101...; seg_o 0011001 while an_o=1110.
REQ-035 Test 2, leading-zero blanking: digits 0x0070, blank_lz=1 -> digits 3 and 2 blank, digit 1 shows 1111000, digit 0 shows 1000000; digits 0x0000 -> only digit 0 lit, showing 1000000.
REQ-036 Test 3, invalid code and dp: digit 2=0xB, dp_mask=0100 -> seg_o=0111111 and dp_o=0 in slot 2 only.
REQ-037 Test 4, tearing: change digits_i from 0x1234 to 0x5678 mid-frame -> the rest of the frame shows 1234; the next frame shows 5678; frame_o pulses exactly once per 16 cycles.
REQ-038 Test 5, blink: BLINK_FRAMES=2, blink_mask=0001 -> digit 0 is blanked in frames 2-3 and lit in frames 0-1 and 4-5; other digits stay lit.
REQ-039 Test 6, disable and reset mid-frame: drop en_i at index 2 -> outputs all ones next cycle; re-raise -> restarts at index 0; a reset pulse mid-frame gives the same restart.
